// File: rtl/calc_sequencer_if.sv
// Operand/handshake/display bundle for calc_sequencer.
// master: the requesting side (drives operands and start).
// slave: the sequencer itself.
interface calc_sequencer_if;
  logic [3:0] i0;
  logic [3:0] i1;
  logic [1:0] sel;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] ans_r;
  logic       sign_out;
  logic [6:0] show_num;
  logic [5:0] show_place;

  modport master (
    output i0, i1, sel, start,
    input  busy, done, ans_r, sign_out, show_num, show_place
  );

  modport slave (
    input  i0, i1, sel, start,
    output busy, done, ans_r, sign_out, show_num, show_place
  );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: 4-bit zero/add/subtract/multiply unit with a sequential
// binary-to-BCD converter and a multiplexed active-low 7-segment scanner.
// Optional feature macro: CALC_SEQ_SIGN_DIGIT_EN adds a sign digit phase
// in front of the hundreds digit in the display scan.
module calc_sequencer #(
  parameter int unsigned SCAN_DIV = 4000
) (
  input  logic             clk_original,
  input  logic             rst_n,
  calc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

`ifdef CALC_SEQ_SIGN_DIGIT_EN
  localparam logic [1:0] PH_SIGN  = 2'd0;
  localparam logic [1:0] PH_HUND  = 2'd1;
  localparam logic [1:0] PH_TENS  = 2'd2;
  localparam logic [1:0] PH_UNITS = 2'd3;
  localparam logic [1:0] PH_FIRST = PH_SIGN;
`else
  localparam logic [1:0] PH_HUND  = 2'd0;
  localparam logic [1:0] PH_TENS  = 2'd1;
  localparam logic [1:0] PH_UNITS = 2'd2;
  localparam logic [1:0] PH_FIRST = PH_HUND;
`endif

  state_t      state, state_nxt;

  logic        start_q;
  logic        armed;
  logic        start_edge;

  logic [3:0]  a_q, b_q;
  logic [1:0]  op_q;
  logic [7:0]  mcand_q;
  logic [3:0]  mplier_q;
  logic [7:0]  acc_q;
  logic [1:0]  mul_cnt_q;
  logic [7:0]  res_q;
  logic        sign_q;
  logic [19:0] dd_q;
  logic [2:0]  conv_cnt_q;

  logic [7:0]  calc_res;
  logic        calc_sign;
  logic        calc_last;
  logic        conv_last;
  logic [19:0] dd_nxt;
  logic [8:0]  sub_res;

  logic [7:0]  ans_q;
  logic        sign_out_q;
  logic [3:0]  hund_q, tens_q, units_q;

  logic [15:0] scan_cnt;
  logic [1:0]  phase;

  logic        busy_w;
  logic        done_w;
  logic [6:0]  num_w;
  logic [5:0]  place_w;

  // Signed difference of two unsigned nibbles, returned as {negative, magnitude}.
  function automatic logic [8:0] sub_mag(input logic [3:0] a, input logic [3:0] b);
    logic signed [5:0] d;
    logic        [5:0] m;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
    if (d < 0) begin
      m = -d;
      return {1'b1, 2'b00, m};
    end
    m = d;
    return {1'b0, 2'b00, m};
  endfunction

  // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift left.
  // Layout: [19:16] hundreds, [15:12] tens, [11:8] units, [7:0] binary.
  function automatic logic [19:0] dd_step(input logic [19:0] x);
    logic [19:0] y;
    y = x;
    if (y[11:8]  >= 4'd5) y[11:8]  = y[11:8]  + 4'd3;
    if (y[15:12] >= 4'd5) y[15:12] = y[15:12] + 4'd3;
    if (y[19:16] >= 4'd5) y[19:16] = y[19:16] + 4'd3;
    return {y[18:0], 1'b0};
  endfunction

  // Active-low segment pattern {a,b,c,d,e,f,g} for a decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // A start level present at reset release must drop before it can start anything.
  assign start_edge = bus.start & ~start_q & armed;

  // Control registers: FSM state.
  always_ff @(posedge clk_original or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = CALC;
      CALC:    if (calc_last)  state_nxt = CONV;
      CONV:    if (conv_last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_w = (state == CALC) || (state == CONV);
    done_w = (state == DONE);
  end

  // Control registers: start edge detector and step counters.
  always_ff @(posedge clk_original or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      armed      <= 1'b0;
      mul_cnt_q  <= 2'd0;
      conv_cnt_q <= 3'd0;
    end else begin
      start_q    <= bus.start;
      armed      <= armed | ~bus.start;
      mul_cnt_q  <= (state == CALC) ? mul_cnt_q + 2'd1 : 2'd0;
      conv_cnt_q <= (state == CONV) ? conv_cnt_q + 3'd1 : 3'd0;
    end
  end

  // Arithmetic result for the current CALC cycle and next conversion step.
  always_comb begin
    calc_res  = 8'd0;
    calc_sign = 1'b0;
    sub_res   = 9'd0;
    case (op_q)
      2'b01:   calc_res = {4'b0000, a_q} + {4'b0000, b_q};
      2'b10: begin
        sub_res   = sub_mag(a_q, b_q);
        calc_sign = sub_res[8];
        calc_res  = sub_res[7:0];
      end
      2'b11:   calc_res = acc_q + (mplier_q[0] ? mcand_q : 8'd0);
      default: calc_res = 8'd0;
    endcase
    calc_last = (op_q != 2'b11) || (mul_cnt_q == 2'd3);
    conv_last = (conv_cnt_q == 3'd7);
    dd_nxt    = dd_step(dd_q);
  end

  // Datapath working registers: operand capture, multiply steps, BCD shifter.
  always_ff @(posedge clk_original) begin
    if (state == IDLE && start_edge) begin
      a_q      <= bus.i0;
      b_q      <= bus.i1;
      op_q     <= bus.sel;
      mcand_q  <= {4'b0000, bus.i0};
      mplier_q <= bus.i1;
      acc_q    <= 8'd0;
    end else if (state == CALC) begin
      acc_q    <= calc_res;
      mcand_q  <= {mcand_q[6:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[3:1]};
      if (calc_last) begin
        res_q  <= calc_res;
        sign_q <= calc_sign;
        dd_q   <= {12'd0, calc_res};
      end
    end else if (state == CONV) begin
      dd_q <= dd_nxt;
    end
  end

  // Committed result: all display-visible values change together on entry to DONE.
  always_ff @(posedge clk_original or negedge rst_n) begin
    if (!rst_n) begin
      ans_q      <= 8'd0;
      sign_out_q <= 1'b0;
      hund_q     <= 4'd0;
      tens_q     <= 4'd0;
      units_q    <= 4'd0;
    end else if (state == CONV && conv_last) begin
      ans_q      <= res_q;
      sign_out_q <= sign_q;
      hund_q     <= dd_nxt[19:16];
      tens_q     <= dd_nxt[15:12];
      units_q    <= dd_nxt[11:8];
    end
  end

  // Free-running scan divider and digit phase, independent of the FSM.
  always_ff @(posedge clk_original or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= 16'd0;
      phase    <= PH_HUND;
    end else if (scan_cnt == 16'(SCAN_DIV - 1)) begin
      scan_cnt <= 16'd0;
      phase    <= (phase == PH_UNITS) ? PH_FIRST : phase + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  // Digit select and segment decode for the current scan phase.
  always_comb begin
    place_w = 6'b111111;
    num_w   = 7'b1111111;
    case (phase)
      PH_HUND: begin
        place_w = 6'b111011;
        num_w   = seg7(hund_q);
      end
      PH_TENS: begin
        place_w = 6'b111101;
        num_w   = seg7(tens_q);
      end
      PH_UNITS: begin
        place_w = 6'b111110;
        num_w   = seg7(units_q);
      end
      default: begin
        place_w = 6'b111111;
        num_w   = 7'b1111111;
      end
    endcase
`ifdef CALC_SEQ_SIGN_DIGIT_EN
    if (phase == PH_SIGN && sign_out_q) begin
      place_w = 6'b110111;
      num_w   = 7'b1111110;
    end
`endif
  end

  assign bus.busy       = busy_w;
  assign bus.done       = done_w;
  assign bus.ans_r      = ans_q;
  assign bus.sign_out   = sign_out_q;
  assign bus.show_num   = num_w;
  assign bus.show_place = place_w;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed testbench for calc_sequencer (SCAN_DIV = 4).
module tb_calc_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  calc_sequencer_if bus ();

  calc_sequencer #(.SCAN_DIV(4)) dut (
    .clk_original (clk),
    .rst_n        (rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] i0;
    logic [3:0] i1;
    int         ans;
    int         sgn;
    int         lat;
    int         h;
    int         t;
    int         u;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Starts one operation; returns the done latency (-1 on timeout) and busy cycles.
  task automatic run_op(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b,
                        output int lat, output int bcyc);
    int n;
    lat  = -1;
    bcyc = 0;
    bus.sel   = s;
    bus.i0    = a;
    bus.i1    = b;
    bus.start = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 40 && lat < 0) begin
      @(negedge clk);
      n++;
      if (bus.busy) bcyc++;
      if (bus.done) lat = n;
      if (n == 1) begin
        bus.start = 1'b0;
        bus.i0    = ~a;
        bus.i1    = ~b;
        bus.sel   = ~s;
      end
    end
  endtask

  task automatic check_display(input int h, input int t, input int u, input int sgn);
    bit seen [4];
    for (int k = 0; k < 4; k++) seen[k] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      case (bus.show_place)
        6'b111011: if (!seen[0]) begin seen[0] = 1'b1; check("disp_hund", bus.show_num, seg_of(h)); end
        6'b111101: if (!seen[1]) begin seen[1] = 1'b1; check("disp_tens", bus.show_num, seg_of(t)); end
        6'b111110: if (!seen[2]) begin seen[2] = 1'b1; check("disp_units", bus.show_num, seg_of(u)); end
        6'b110111: if (!seen[3]) begin
          seen[3] = 1'b1;
          check("disp_sign_num", bus.show_num, 7'b1111110);
          check("disp_sign_allowed", 1, sgn);
        end
        default: ;
      endcase
    end
    check("disp_all_digits", int'(seen[0] & seen[1] & seen[2]), 1);
`ifdef CALC_SEQ_SIGN_DIGIT_EN
    check("disp_sign_seen", int'(seen[3]), sgn);
`endif
  endtask

  initial begin
    logic [5:0] places [3];
    int lat, bcyc, dones, busy_seen, got_ans;

    total = 0;
    bad   = 0;
    places[0] = 6'b111011;
    places[1] = 6'b111101;
    places[2] = 6'b111110;

    vecs[0]  = '{2'b01, 4'd9,  4'd8,  17,  0, 10, 0, 1, 7};
    vecs[1]  = '{2'b10, 4'd3,  4'd12, 9,   1, 10, 0, 0, 9};
    vecs[2]  = '{2'b11, 4'd15, 4'd15, 225, 0, 13, 2, 2, 5};
    vecs[3]  = '{2'b00, 4'd7,  4'd5,  0,   0, 10, 0, 0, 0};
    vecs[4]  = '{2'b10, 4'd12, 4'd3,  9,   0, 10, 0, 0, 9};
    vecs[5]  = '{2'b10, 4'd5,  4'd5,  0,   0, 10, 0, 0, 0};
    vecs[6]  = '{2'b01, 4'd15, 4'd15, 30,  0, 10, 0, 3, 0};
    vecs[7]  = '{2'b11, 4'd0,  4'd13, 0,   0, 13, 0, 0, 0};
    vecs[8]  = '{2'b11, 4'd13, 4'd11, 143, 0, 13, 1, 4, 3};
    vecs[9]  = '{2'b11, 4'd1,  4'd15, 15,  0, 13, 0, 1, 5};
    vecs[10] = '{2'b10, 4'd0,  4'd15, 15,  1, 10, 0, 1, 5};

    bus.start = 1'b0;
    bus.sel   = 2'b00;
    bus.i0    = 4'd0;
    bus.i1    = 4'd0;
    rst_n     = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ans", bus.ans_r, 0);
    check("rst_sign", bus.sign_out, 0);
    check("rst_place", bus.show_place, 6'b111011);
    check("rst_num", bus.show_num, 7'b0000001);

    // Scan order and rate right after reset release.
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("scan_place_%0d", k), bus.show_place, places[(k / 4) % 3]);
    end

    // Table-driven operations.
    for (int v = 0; v < 11; v++) begin
      run_op(vecs[v].sel, vecs[v].i0, vecs[v].i1, lat, bcyc);
      check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      check($sformatf("v%0d_busy_cycles", v), bcyc, vecs[v].lat - 1);
      check($sformatf("v%0d_ans", v), bus.ans_r, vecs[v].ans);
      check($sformatf("v%0d_sign", v), bus.sign_out, vecs[v].sgn);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", v), bus.done, 0);
      check_display(vecs[v].h, vecs[v].t, vecs[v].u, vecs[v].sgn);
    end

    // Back-to-back: new start in the first IDLE cycle after DONE.
    run_op(2'b01, 4'd4, 4'd5, lat, bcyc);
    check("b2b_first_ans", bus.ans_r, 9);
    @(negedge clk);
    check("b2b_done_pulse", bus.done, 0);
    run_op(2'b11, 4'd6, 4'd7, lat, bcyc);
    check("b2b_second_latency", lat, 13);
    check("b2b_second_ans", bus.ans_r, 42);
    @(negedge clk);

    // Second start edge mid-operation with changed operand is ignored.
    bus.sel   = 2'b01;
    bus.i0    = 4'd9;
    bus.i1    = 4'd8;
    bus.start = 1'b1;
    @(posedge clk);
    dones   = 0;
    got_ans = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        got_ans = bus.ans_r;
      end
      if (n == 1) bus.start = 1'b0;
      if (n == 3) begin
        bus.start = 1'b1;
        bus.i0    = 4'd2;
      end
    end
    bus.start = 1'b0;
    check("ignore_done_count", dones, 1);
    check("ignore_ans", got_ans, 17);

    // Reset during CONV with start held high through and after reset.
    @(negedge clk);
    bus.sel   = 2'b11;
    bus.i0    = 4'd15;
    bus.i1    = 4'd15;
    bus.start = 1'b1;
    @(posedge clk);
    repeat (6) @(negedge clk);
    check("pre_abort_busy", bus.busy, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_rst_ans", bus.ans_r, 0);
    check("abort_rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    dones     = 0;
    busy_seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.busy) busy_seen++;
    end
    check("abort_no_done", dones, 0);
    check("abort_no_restart", busy_seen, 0);
    check("abort_ans", bus.ans_r, 0);
    check("abort_sign", bus.sign_out, 0);
    check_display(0, 0, 0, 0);
    bus.start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
